// File: rtl/bti_addr_dec_pkg.sv
// Shared BTI types for the address decoder slice.
// Packet layouts, decode targets and order-FIFO entry.
package bti_addr_dec_pkg;

  localparam int BTI_TIDW   = 4;
  localparam int BTI_ADDR_W = 32;
  localparam int BTI_DATA_W = 32;

  typedef enum logic [1:0] {
    BTI_TGT_S0  = 2'd0,
    BTI_TGT_S1  = 2'd1,
    BTI_TGT_ERR = 2'd2
  } bti_tgt_e;

  typedef struct packed {
    logic [BTI_TIDW-1:0]   tid;
    logic                  we;
    logic [3:0]            be;
    logic [BTI_ADDR_W-1:0] addr;
    logic [BTI_DATA_W-1:0] wdata;
  } bti_req_pkt_t;

  typedef struct packed {
    logic [BTI_TIDW-1:0]   tid;
    logic [BTI_DATA_W-1:0] data;
    logic                  ok;
  } bti_rsp_pkt_t;

  typedef struct packed {
    bti_tgt_e            tgt;
    logic [BTI_TIDW-1:0] tid;
  } ord_ent_t;

endpackage

// File: rtl/bti_addr_dec_if.sv
// BTI request and response channels.
// vld/rdy handshake with a packed payload.
interface bti_req_if_t;
  import bti_addr_dec_pkg::*;
  logic         vld;
  logic         rdy;
  bti_req_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

interface bti_rsp_if_t;
  import bti_addr_dec_pkg::*;
  logic         vld;
  logic         rdy;
  bti_rsp_pkt_t pkt;
  modport mst (output vld, output pkt, input rdy);
  modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/bti_addr_dec_sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Pointers wrap naturally; DEPTH is a power of two.
module sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // storage write at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // pointer advance, wrapping modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // occupancy: push and pop together leave it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign cnt   = r_cnt;

endmodule

// File: rtl/bti_addr_dec.sv
// BTI address demux: one master to ROM/RAM slaves.
// Responses return in request order via an order FIFO.
module bti_addr_dec
  import bti_addr_dec_pkg::*;
#(
  parameter int              BTI_AW   = BTI_ADDR_W,
  parameter int              BTI_DW   = BTI_DATA_W,
  parameter logic [BTI_AW-1:0] S0_BASE  = 32'h0000_0000,
  parameter logic [BTI_AW-1:0] S0_SIZE  = 32'h0002_0000,
  parameter logic [BTI_AW-1:0] S1_BASE  = 32'h8000_0000,
  parameter logic [BTI_AW-1:0] S1_SIZE  = 32'h0001_0000,
  parameter int              OT_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  bti_req_if_t.slv bti_req_slv,
  bti_rsp_if_t.mst bti_rsp_mst,
  bti_req_if_t.mst s0_req_mst,
  bti_req_if_t.mst s1_req_mst,
  bti_rsp_if_t.slv s0_rsp_slv,
  bti_rsp_if_t.slv s1_rsp_slv
);

  localparam int CW = $clog2(OT_DEPTH) + 1;
  localparam logic [BTI_DW-1:0] ERR_DATA = '0;

  logic [BTI_AW-1:0] w_addr;
  bti_tgt_e          w_tgt;
  logic              w_sel_rdy;
  logic              w_req_rdy;
  logic              w_rsp_vld;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_ff_full;
  logic              w_empty;
  logic [CW-1:0]     w_cnt;
  ord_ent_t          w_ent;
  ord_ent_t          w_head;

  assign w_addr = bti_req_slv.pkt.addr;

  // window decode; S0 takes priority on overlap
  always_comb begin
    w_tgt = BTI_TGT_ERR;
    if ((w_addr & ~(S0_SIZE - 1'b1)) == S0_BASE)
      w_tgt = BTI_TGT_S0;
    else if ((w_addr & ~(S1_SIZE - 1'b1)) == S1_BASE)
      w_tgt = BTI_TGT_S1;
  end

  // readiness of the addressed target
  always_comb begin
    w_sel_rdy = 1'b1;
    unique case (w_tgt)
      BTI_TGT_S0: w_sel_rdy = s0_req_mst.rdy;
      BTI_TGT_S1: w_sel_rdy = s1_req_mst.rdy;
      default:    w_sel_rdy = 1'b1;
    endcase
  end

  assign w_full    = (w_cnt == CW'(OT_DEPTH));
  assign w_req_rdy = ~w_full & w_sel_rdy;

  assign bti_req_slv.rdy = w_req_rdy;
  assign s0_req_mst.pkt  = bti_req_slv.pkt;
  assign s1_req_mst.pkt  = bti_req_slv.pkt;
  assign s0_req_mst.vld  = bti_req_slv.vld & ~w_full
                         & (w_tgt == BTI_TGT_S0);
  assign s1_req_mst.vld  = bti_req_slv.vld & ~w_full
                         & (w_tgt == BTI_TGT_S1);

  assign w_push    = bti_req_slv.vld & w_req_rdy;
  assign w_ent.tgt = w_tgt;
  assign w_ent.tid = bti_req_slv.pkt.tid;

  sync_fifo #(
    .DW    ($bits(ord_ent_t)),
    .DEPTH (OT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_ent),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_ff_full),
    .empty (w_empty),
    .cnt   (w_cnt)
  );

  // response mux steered by the oldest outstanding entry
  always_comb begin
    w_rsp_vld       = 1'b0;
    bti_rsp_mst.pkt = '0;
    s0_rsp_slv.rdy  = 1'b0;
    s1_rsp_slv.rdy  = 1'b0;
    if (!w_empty) begin
      unique case (w_head.tgt)
        BTI_TGT_S0: begin
          w_rsp_vld       = s0_rsp_slv.vld;
          bti_rsp_mst.pkt = s0_rsp_slv.pkt;
          s0_rsp_slv.rdy  = bti_rsp_mst.rdy;
        end
        BTI_TGT_S1: begin
          w_rsp_vld       = s1_rsp_slv.vld;
          bti_rsp_mst.pkt = s1_rsp_slv.pkt;
          s1_rsp_slv.rdy  = bti_rsp_mst.rdy;
        end
        default: begin
          w_rsp_vld            = 1'b1;
          bti_rsp_mst.pkt.tid  = w_head.tid;
          bti_rsp_mst.pkt.data = ERR_DATA;
          bti_rsp_mst.pkt.ok   = 1'b0;
        end
      endcase
    end
  end

  assign bti_rsp_mst.vld = w_rsp_vld;
  assign w_pop           = w_rsp_vld & bti_rsp_mst.rdy;

  // local full flag must track the FIFO's own view
  a_full_match: assert property (
    @(posedge clk) disable iff (!rst_n) (w_full == w_ff_full)
  );

endmodule

// File: tb/tb_bti_addr_dec.sv
// Scoreboard bench for bti_addr_dec.
// Directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_bti_addr_dec;
  import bti_addr_dec_pkg::*;

  localparam logic [31:0] S0B = 32'h0000_0000;
  localparam logic [31:0] S0S = 32'h0002_0000;
  localparam logic [31:0] S1B = 32'h8000_0000;
  localparam logic [31:0] S1S = 32'h0001_0000;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bti_req_if_t m_req ();
  bti_rsp_if_t m_rsp ();
  bti_req_if_t s0_req ();
  bti_req_if_t s1_req ();
  bti_rsp_if_t s0_rsp ();
  bti_rsp_if_t s1_rsp ();

  bti_addr_dec dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bti_req_slv (m_req),
    .bti_rsp_mst (m_rsp),
    .s0_req_mst  (s0_req),
    .s1_req_mst  (s1_req),
    .s0_rsp_slv  (s0_rsp),
    .s1_rsp_slv  (s1_rsp)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          tgt;
    logic [3:0]  tid;
    logic [31:0] data;
    logic        ok;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  tid;
    logic [31:0] data;
    int          due;
  } sl_t;
  sl_t sq0[$];
  sl_t sq1[$];

  int cyc = 0;
  int lat0 = 0;
  int lat1 = 0;
  bit hold0 = 0;
  bit hold1 = 0;
  bit mrdy_en = 1;
  bit rnd = 0;
  bit on0 = 0;
  bit on1 = 0;
  bit hs_m, hs_r, hs_s0q, hs_s1q, hs_s0r, hs_s1r;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_tgt(logic [31:0] a);
    longint unsigned x  = a;
    longint unsigned b0 = S0B;
    longint unsigned b1 = S1B;
    if (x >= b0 && x < b0 + S0S) return 0;
    if (x >= b1 && x < b1 + S1S) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] sdata(int s, logic [31:0] a);
    if (s == 0 && a == 32'h10) return 32'hDEAD_BEEF;
    return a ^ ((s == 0) ? 32'h0F0F_1234 : 32'h5A5A_A5A5);
  endfunction

  function automatic bit has_tgt(int s);
    foreach (sb[i]) if (sb[i].tgt == s) return 1;
    return 0;
  endfunction

  // monitor + scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    int t;
    int hd;
    bit full;
    bit erdy;
    bit emv;
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      hs_m = 0; hs_r = 0; hs_s0q = 0;
      hs_s1q = 0; hs_s0r = 0; hs_s1r = 0;
      chk("rst_rsp_vld", m_rsp.vld, 0);
      chk("rst_cnt", dut.u_fifo.cnt, 0);
      chk("rst_s0_vld", s0_req.vld, 0);
      chk("rst_s1_vld", s1_req.vld, 0);
    end else begin
      t = ref_tgt(m_req.pkt.addr);
      full = (sb.size() >= DEPTH);
      erdy = !full && ((t == 2) ? 1'b1 :
             (t == 0) ? s0_req.rdy : s1_req.rdy);
      chk("req_rdy", m_req.rdy, erdy);
      chk("s0_req_vld", s0_req.vld,
          m_req.vld && !full && t == 0);
      chk("s1_req_vld", s1_req.vld,
          m_req.vld && !full && t == 1);
      chk("s0_req_pkt", s0_req.pkt, m_req.pkt);
      chk("s1_req_pkt", s1_req.pkt, m_req.pkt);
      hd = (sb.size() > 0) ? sb[0].tgt : -1;
      emv = (hd == 2) ? 1'b1 : (hd == 0) ? s0_rsp.vld :
            (hd == 1) ? s1_rsp.vld : 1'b0;
      chk("rsp_vld", m_rsp.vld, emv);
      chk("s0_rsp_rdy", s0_rsp.rdy, hd == 0 && m_rsp.rdy);
      chk("s1_rsp_rdy", s1_rsp.rdy, hd == 1 && m_rsp.rdy);
      if (s0_rsp.vld) chk("s0_orphan", has_tgt(0), 1);
      if (s1_rsp.vld) chk("s1_orphan", has_tgt(1), 1);
      hs_m   = m_req.vld && m_req.rdy;
      hs_r   = m_rsp.vld && m_rsp.rdy;
      hs_s0q = s0_req.vld && s0_req.rdy;
      hs_s1q = s1_req.vld && s1_req.rdy;
      hs_s0r = s0_rsp.vld && s0_rsp.rdy;
      hs_s1r = s1_rsp.vld && s1_rsp.rdy;
      if (hs_r) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_tid", m_rsp.pkt.tid, e.tid);
          chk("rsp_data", m_rsp.pkt.data, e.data);
          chk("rsp_ok", m_rsp.pkt.ok, e.ok);
        end
      end
      if (hs_m) begin
        e.tgt  = t;
        e.tid  = m_req.pkt.tid;
        e.data = (t == 2) ? 32'h0 : sdata(t, m_req.pkt.addr);
        e.ok   = (t != 2);
        sb.push_back(e);
      end
    end
  end

  function automatic sl_t mk(logic [3:0] tid, int s,
                             logic [31:0] a, int lat);
    sl_t r;
    r.tid  = tid;
    r.data = sdata(s, a);
    r.due  = cyc + lat;
    return r;
  endfunction

  // in-order slave models and ready generation
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq0.delete(); sq1.delete();
      on0 = 0; on1 = 0;
      s0_rsp.vld = 0; s1_rsp.vld = 0;
      s0_rsp.pkt = '0; s1_rsp.pkt = '0;
      s0_req.rdy = 1; s1_req.rdy = 1;
      m_rsp.rdy = 1;
    end else begin
      cyc++;
      if (hs_s0r) begin void'(sq0.pop_front()); on0 = 0; end
      if (hs_s1r) begin void'(sq1.pop_front()); on1 = 0; end
      if (hs_s0q)
        sq0.push_back(mk(s0_req.pkt.tid, 0, s0_req.pkt.addr, lat0));
      if (hs_s1q)
        sq1.push_back(mk(s1_req.pkt.tid, 1, s1_req.pkt.addr, lat1));
      #1;
      if (!on0 && sq0.size() > 0 && cyc > sq0[0].due &&
          !(hold0 || (rnd && $urandom % 3 == 0))) on0 = 1;
      if (!on1 && sq1.size() > 0 && cyc > sq1[0].due &&
          !(hold1 || (rnd && $urandom % 3 == 0))) on1 = 1;
      s0_rsp.vld = on0;
      s1_rsp.vld = on1;
      if (on0) begin
        s0_rsp.pkt.tid = sq0[0].tid;
        s0_rsp.pkt.data = sq0[0].data;
        s0_rsp.pkt.ok = 1'b1;
      end
      if (on1) begin
        s1_rsp.pkt.tid = sq1[0].tid;
        s1_rsp.pkt.data = sq1[0].data;
        s1_rsp.pkt.ok = 1'b1;
      end
      s0_req.rdy = rnd ? ($urandom % 4 != 0) : 1'b1;
      s1_req.rdy = rnd ? ($urandom % 4 != 0) : 1'b1;
      m_rsp.rdy  = rnd ? ($urandom % 3 != 0) : mrdy_en;
    end
  end

  // issue one request; entered and left at posedge+1
  task automatic send(logic [31:0] a, logic [3:0] tid);
    int n = 0;
    m_req.vld = 1;
    m_req.pkt.addr = a;
    m_req.pkt.tid = tid;
    m_req.pkt.we = 1'($urandom);
    m_req.pkt.be = 4'($urandom);
    m_req.pkt.wdata = $urandom;
    forever begin
      @(negedge clk);
      if (m_req.rdy) break;
      n++;
      if (n > 300) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    m_req.vld = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0) break;
      n++;
      if (n > 500) begin
        chk("idle_timeout", sb.size(), 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] bnd [8];
    bnd = '{32'h0, S0S - 1, S0S, S1B - 1,
            S1B, S1B + S1S - 1, S1B + S1S, 32'hFFFF_FFFF};
    case ($urandom % 4)
      0: return S0B + ($urandom % S0S);
      1: return S1B + ($urandom % S1S);
      2: return $urandom;
      default: return bnd[$urandom % 8];
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_req.vld = 0;
    m_req.pkt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    lat0 = 0;
    send(32'h0000_0010, 4'd3);
    wait_idle();

    lat1 = 1;
    send(32'h8000_0004, 4'd1);
    wait_idle();

    send(32'h4000_0000, 4'd5);
    wait_idle();

    lat0 = 0; lat1 = 4;
    send(32'h8000_0100, 4'd1);
    send(32'h0000_0200, 4'd2);
    wait_idle();

    lat1 = 0;
    hold0 = 1;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(32'h100 + 32'(i * 4), 4'(i + 6));
      end
      begin
        repeat (10) @(negedge clk);
        chk("full_cnt", dut.u_fifo.cnt, 4);
        chk("full_rdy", m_req.rdy, 0);
        hold0 = 0;
      end
    join
    wait_idle();

    mrdy_en = 0; hold0 = 1; hold1 = 1;
    send(32'h4000_0000, 4'd7);
    send(32'h0000_0010, 4'd8);
    send(32'h8000_0000, 4'd9);
    chk("pre_rst_vld", m_rsp.vld, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_vld", m_rsp.vld, 0);
    chk("mid_rst_cnt", dut.u_fifo.cnt, 0);
    hold0 = 0; hold1 = 0; mrdy_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    send(32'h0000_0010, 4'd4);
    wait_idle();

    rnd = 1;
    for (int i = 0; i < 300; i++) begin
      if (i % 20 == 0) begin
        lat0 = $urandom % 4;
        lat1 = $urandom % 4;
      end
      send(rnd_addr(), 4'($urandom));
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd = 0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
